// File: rtl/life_pkg.sv
// life_pkg: board geometry defaults, word/address types and engine states
// shared by the Game of Life engine, double_buffer and the renderer.
package life_pkg;

   localparam int DEF_WORD_W   = 16;
   localparam int DEF_W_WORDS  = 4;
   localparam int DEF_BOARD_H  = 64;
   localparam int DEF_READ_LAT = 2;
   localparam int DEF_ADDR_W   = $clog2(DEF_W_WORDS * DEF_BOARD_H);

   typedef logic [DEF_WORD_W-1:0] data_t;
   typedef logic [DEF_ADDR_W-1:0] addr_t;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_FETCH = 3'd1;
   localparam state_t S_STEP  = 3'd2;
   localparam state_t S_SWAP  = 3'd3;
   localparam state_t S_WAIT  = 3'd4;

endpackage

// File: rtl/life_logic_engine_word_rule.sv
// life_word_rule: B3/S23 next-state for the centre word of a 3x3 word window;
// edge bits borrow the adjacent bit of the neighbouring column.
module life_word_rule
   import life_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic [WORD_W-1:0] up_p,
   input  logic [WORD_W-1:0] up_c,
   input  logic [WORD_W-1:0] up_n,
   input  logic [WORD_W-1:0] md_p,
   input  logic [WORD_W-1:0] md_c,
   input  logic [WORD_W-1:0] md_n,
   input  logic [WORD_W-1:0] dn_p,
   input  logic [WORD_W-1:0] dn_c,
   input  logic [WORD_W-1:0] dn_n,
   output logic [WORD_W-1:0] next_o
);

   logic [WORD_W+1:0] up_x;
   logic [WORD_W+1:0] md_x;
   logic [WORD_W+1:0] dn_x;
   logic [3:0]        cnt;

   // Bit i of a row sits at x[i+1]; x[0] and x[WORD_W+1] are the neighbours.
   assign up_x = {up_n[0], up_c, up_p[WORD_W-1]};
   assign md_x = {md_n[0], md_c, md_p[WORD_W-1]};
   assign dn_x = {dn_n[0], dn_c, dn_p[WORD_W-1]};

   always_comb begin
      next_o = '0;
      cnt    = '0;
      for (int i = 0; i < WORD_W; i++) begin
         cnt = 4'(up_x[i]) + 4'(up_x[i+1]) + 4'(up_x[i+2])
             + 4'(md_x[i])                 + 4'(md_x[i+2])
             + 4'(dn_x[i]) + 4'(dn_x[i+1]) + 4'(dn_x[i+2]);
         next_o[i] = (cnt == 4'd3) || (md_x[i+1] && (cnt == 4'd2));
      end
   end

endmodule

// File: rtl/life_logic_engine.sv
// life_logic_engine: sweeps the logic ports of double_buffer once per start,
// writing one Game of Life generation into the back buffer and swapping.
module life_logic_engine
   import life_pkg::*;
#(
   parameter int WORD_W   = DEF_WORD_W,
   parameter int W_WORDS  = DEF_W_WORDS,
   parameter int BOARD_H  = DEF_BOARD_H,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic                                 clk_130mhz,
   input  logic                                 rst_n_in,
   input  logic                                 start_in,
   input  logic                                 db_ready_in,
   output logic [$clog2(W_WORDS*BOARD_H)-1:0]   logic_addr_r,
   input  logic [WORD_W-1:0]                    logic_data_r,
   output logic [$clog2(W_WORDS*BOARD_H)-1:0]   logic_addr_w,
   output logic [WORD_W-1:0]                    logic_data_w,
   output logic                                 logic_wr_en,
   output logic                                 swap_out,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic [15:0]                          gen_count_out
);

   localparam int AW   = $clog2(W_WORDS * BOARD_H);
   localparam int RW   = $clog2(BOARD_H);
   localparam int SW   = $clog2(W_WORDS + 1);
   localparam int CW   = $clog2(READ_LAT + 3);
   localparam int LAST = READ_LAT + 2;

   state_t state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [SW-1:0] step_q, step_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Window [row][col]: row 0/1/2 = y-1/y/y+1, col 0/1/2 = prev/cur/next.
   logic [2:0][2:0][WORD_W-1:0] win_q, win_d, ld_win;

   logic [AW-1:0]     addr_r_q, addr_r_d;
   logic [AW-1:0]     addr_w_q, addr_w_d;
   logic [WORD_W-1:0] data_w_q, data_w_d;
   logic [WORD_W-1:0] rule_word;
   logic              wr_q, wr_d;
   logic              swap_q, swap_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       gen_q, gen_d;

   logic       ld_en;
   logic [1:0] ld_sel;
   logic       fetch_go;
   logic       rd_go;
   int         rd_row;
   int         rd_step;
   int         rd_k;

   function automatic logic row_ok(int row, int step, int k);
      int r;
      r = row - 1 + k;
      return (r >= 0) && (r < BOARD_H) && (step < W_WORDS);
   endfunction

   function automatic logic [AW-1:0] row_addr(int row, int step, int k);
      return AW'((row - 1 + k) * W_WORDS + step);
   endfunction

   // Slot k was addressed in FETCH cycle k; its word lands READ_LAT later.
   always_comb begin
      ld_win = win_q;
      ld_en  = (state_q == S_FETCH) && (cnt_q >= CW'(READ_LAT));
      ld_sel = 2'(cnt_q - CW'(READ_LAT));
      if (ld_en) begin
         ld_win[ld_sel][2] = row_ok(int'(row_q), int'(step_q), int'(ld_sel))
                           ? logic_data_r : '0;
      end
   end

   life_word_rule #(
      .WORD_W (WORD_W)
   ) u_rule (
      .up_p   (ld_win[0][0]),
      .up_c   (ld_win[0][1]),
      .up_n   (ld_win[0][2]),
      .md_p   (ld_win[1][0]),
      .md_c   (ld_win[1][1]),
      .md_n   (ld_win[1][2]),
      .dn_p   (ld_win[2][0]),
      .dn_c   (ld_win[2][1]),
      .dn_n   (ld_win[2][2]),
      .next_o (rule_word)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      win_d    = win_q;
      addr_w_d = addr_w_q;
      data_w_d = data_w_q;
      wr_d     = 1'b0;
      swap_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      gen_d    = gen_q;
      fetch_go = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_in && db_ready_in) begin
               state_d  = S_FETCH;
               row_d    = '0;
               step_d   = '0;
               cnt_d    = '0;
               win_d    = '0;
               busy_d   = 1'b1;
               fetch_go = 1'b1;
            end
         end
         S_FETCH: begin
            win_d = ld_win;
            cnt_d = cnt_q + 1'b1;
            // Result is registered so the write shows in the STEP cycle.
            if (cnt_q == CW'(LAST)) begin
               state_d = S_STEP;
               if (step_q != '0) begin
                  wr_d     = 1'b1;
                  data_w_d = rule_word;
                  addr_w_d = AW'(int'(row_q) * W_WORDS + int'(step_q) - 1);
               end
            end
         end
         S_STEP: begin
            cnt_d    = '0;
            fetch_go = 1'b1;
            if (step_q != SW'(W_WORDS)) begin
               step_d  = step_q + 1'b1;
               state_d = S_FETCH;
               for (int r = 0; r < 3; r++) begin
                  win_d[r][0] = win_q[r][1];
                  win_d[r][1] = win_q[r][2];
                  win_d[r][2] = '0;
               end
            end else begin
               win_d  = '0;
               step_d = '0;
               if (row_q == RW'(BOARD_H - 1)) begin
                  state_d  = S_SWAP;
                  fetch_go = 1'b0;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_SWAP: begin
            if (db_ready_in) begin
               swap_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // The buffer drops ready one cycle late, so skip the first cycle.
            if (cnt_q == '0) begin
               cnt_d = CW'(1);
            end else if (db_ready_in) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               gen_d   = gen_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      addr_r_d = addr_r_q;
      rd_go    = fetch_go;
      rd_row   = int'(row_d);
      rd_step  = int'(step_d);
      rd_k     = 0;
      if (state_q == S_FETCH && cnt_q < CW'(2)) begin
         rd_go   = 1'b1;
         rd_row  = int'(row_q);
         rd_step = int'(step_q);
         rd_k    = int'(cnt_q) + 1;
      end
      if (rd_go && row_ok(rd_row, rd_step, rd_k)) begin
         addr_r_d = row_addr(rd_row, rd_step, rd_k);
      end
   end

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         step_q   <= '0;
         cnt_q    <= '0;
         win_q    <= '0;
         addr_r_q <= '0;
         addr_w_q <= '0;
         data_w_q <= '0;
         wr_q     <= 1'b0;
         swap_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gen_q    <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         addr_r_q <= addr_r_d;
         addr_w_q <= addr_w_d;
         data_w_q <= data_w_d;
         wr_q     <= wr_d;
         swap_q   <= swap_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         gen_q    <= gen_d;
      end
   end

   assign logic_addr_r  = addr_r_q;
   assign logic_addr_w  = addr_w_q;
   assign logic_data_w  = data_w_q;
   assign logic_wr_en   = wr_q;
   assign swap_out      = swap_q;
   assign busy_out      = busy_q;
   assign done_out      = done_q;
   assign gen_count_out = gen_q;

endmodule

// File: tb/tb_life_logic_engine.sv
// tb_life_logic_engine: directed Game of Life patterns against a two-buffer
// memory model with a two-cycle logic read pipeline.
module tb_life_logic_engine;
   import life_pkg::*;

   localparam int WW     = DEF_WORD_W;
   localparam int NW     = DEF_W_WORDS;
   localparam int BH     = DEF_BOARD_H;
   localparam int RL     = DEF_READ_LAT;
   localparam int NWORDS = NW * BH;
   localparam int CORE   = BH * (NW + 1) * (RL + 4);

   logic  clk_130mhz  = 1'b0;
   logic  rst_n_in    = 1'b0;
   logic  start_in    = 1'b0;
   logic  db_ready_in = 1'b1;
   addr_t logic_addr_r;
   data_t logic_data_r;
   addr_t logic_addr_w;
   data_t logic_data_w;
   logic  logic_wr_en;
   logic  swap_out;
   logic  busy_out;
   logic  done_out;
   logic [15:0] gen_count_out;

   always #4 clk_130mhz = ~clk_130mhz;

   life_logic_engine dut (
      .clk_130mhz    (clk_130mhz),
      .rst_n_in      (rst_n_in),
      .start_in      (start_in),
      .db_ready_in   (db_ready_in),
      .logic_addr_r  (logic_addr_r),
      .logic_data_r  (logic_data_r),
      .logic_addr_w  (logic_addr_w),
      .logic_data_w  (logic_data_w),
      .logic_wr_en   (logic_wr_en),
      .swap_out      (swap_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .gen_count_out (gen_count_out)
   );

   data_t rd_mem [NWORDS];
   data_t wr_mem [NWORDS];
   data_t rd_d1 = '0;
   data_t rd_d2 = '0;
   int    wr_cnt   = 0;
   int    wr_nz    = 0;
   int    swap_cnt = 0;
   addr_t last_wa  = '0;

   int vectors     = 0;
   int miscompares = 0;
   int exp_gen     = 0;

   always @(posedge clk_130mhz) begin
      rd_d1 <= rd_mem[logic_addr_r];
      rd_d2 <= rd_d1;
   end
   assign logic_data_r = rd_d2;

   always @(posedge clk_130mhz) begin
      if (logic_wr_en) begin
         wr_mem[logic_addr_w] <= logic_data_w;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= logic_addr_w;
         if (logic_data_w != '0) wr_nz <= wr_nz + 1;
      end
      if (swap_out) swap_cnt <= swap_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int widx(int y, int c);
      return y * NW + c;
   endfunction

   function automatic int board_pop();
      int s = 0;
      for (int i = 0; i < NWORDS; i++) s += $countones(rd_mem[i]);
      return s;
   endfunction

   task automatic clear_board();
      for (int i = 0; i < NWORDS; i++) rd_mem[i] = '0;
   endtask

   task automatic set_cell(input int x, input int y);
      rd_mem[widx(y, x / WW)][x % WW] = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk_130mhz);
      start_in = 1'b1;
      @(negedge clk_130mhz);
      start_in = 1'b0;
   endtask

   task automatic take_swap();
      for (int i = 0; i < NWORDS; i++) rd_mem[i] = wr_mem[i];
   endtask

   task automatic run_gen(input string tag);
      int s0;
      int n;
      s0 = swap_cnt;
      pulse_start();
      n = 0;
      while (!done_out && n < 3 * CORE) begin
         @(negedge clk_130mhz);
         n++;
      end
      exp_gen++;
      chk({tag, "_done"}, done_out, 1);
      chk({tag, "_swaps"}, swap_cnt - s0, 1);
      chk({tag, "_gen"}, gen_count_out, exp_gen);
      take_swap();
   endtask

   initial begin
      #(80 * CORE * 8);
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int w0;
      int s0;
      clear_board();
      for (int i = 0; i < NWORDS; i++) wr_mem[i] = '0;

      repeat (2) @(negedge clk_130mhz);
      chk("rst_wr_en", logic_wr_en, 0);
      chk("rst_swap", swap_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_gen", gen_count_out, 0);
      chk("rst_addr_r", logic_addr_r, 0);
      chk("rst_addr_w", logic_addr_w, 0);
      chk("rst_data_w", logic_data_w, 0);
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_130mhz);

      db_ready_in = 1'b0;
      pulse_start();
      repeat (3) @(negedge clk_130mhz);
      chk("start_not_ready", busy_out, 0);
      db_ready_in = 1'b1;

      clear_board();
      set_cell(1, 1);
      set_cell(2, 1);
      set_cell(3, 1);
      run_gen("blinker");
      chk("blinker_r0", rd_mem[widx(0, 0)], 16'h0004);
      chk("blinker_r1", rd_mem[widx(1, 0)], 16'h0004);
      chk("blinker_r2", rd_mem[widx(2, 0)], 16'h0004);
      chk("blinker_pop", board_pop(), 3);

      // Empty board: one SWAP-state cycle precedes the registered pulse.
      clear_board();
      w0 = wr_cnt;
      s0 = wr_nz;
      chk("empty_idle_busy", busy_out, 0);
      pulse_start();
      chk("empty_busy_rise", busy_out, 1);
      n = 0;
      while (!swap_out && n < 2 * CORE) begin
         @(negedge clk_130mhz);
         n++;
      end
      chk("empty_latency", n, CORE + 1);
      chk("empty_wr_pulses", wr_cnt - w0, NWORDS);
      chk("empty_nonzero", wr_nz - s0, 0);
      chk("empty_last_addr", last_wa, NWORDS - 1);
      @(negedge clk_130mhz);
      chk("empty_done_early", done_out, 0);
      @(negedge clk_130mhz);
      exp_gen++;
      chk("empty_done", done_out, 1);
      chk("empty_busy_fall", busy_out, 0);
      chk("empty_gen", gen_count_out, exp_gen);
      take_swap();

      clear_board();
      set_cell(15, 5);
      set_cell(16, 5);
      set_cell(15, 6);
      set_cell(16, 6);
      run_gen("block1");
      run_gen("block2");
      run_gen("block3");
      chk("block_gen", gen_count_out, 5);
      chk("block_r5c0", rd_mem[widx(5, 0)], 16'h8000);
      chk("block_r5c1", rd_mem[widx(5, 1)], 16'h0001);
      chk("block_r6c0", rd_mem[widx(6, 0)], 16'h8000);
      chk("block_r6c1", rd_mem[widx(6, 1)], 16'h0001);
      chk("block_pop", board_pop(), 4);

      clear_board();
      set_cell(0, 0);
      set_cell(1, 0);
      set_cell(0, 1);
      run_gen("corner1");
      chk("corner1_r0", rd_mem[widx(0, 0)], 16'h0003);
      chk("corner1_r1", rd_mem[widx(1, 0)], 16'h0003);
      chk("corner1_far", rd_mem[widx(BH - 1, NW - 1)], 0);
      chk("corner1_r0c3", rd_mem[widx(0, NW - 1)], 0);
      chk("corner1_pop", board_pop(), 4);
      run_gen("corner2");
      chk("corner2_r0", rd_mem[widx(0, 0)], 16'h0003);
      chk("corner2_r1", rd_mem[widx(1, 0)], 16'h0003);
      chk("corner2_pop", board_pop(), 4);

      w0 = wr_cnt;
      s0 = swap_cnt;
      pulse_start();
      repeat (100) @(negedge clk_130mhz);
      pulse_start();
      n = 0;
      while ((wr_cnt - w0) < NWORDS && n < 2 * CORE) begin
         @(negedge clk_130mhz);
         n++;
      end
      chk("hold_writes", wr_cnt - w0, NWORDS);
      db_ready_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_130mhz);
         chk("hold_no_swap", swap_out, 0);
      end
      db_ready_in = 1'b1;
      @(negedge clk_130mhz);
      chk("hold_swap", swap_out, 1);
      db_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_130mhz);
         chk("hold_no_done", done_out, 0);
      end
      db_ready_in = 1'b1;
      @(negedge clk_130mhz);
      exp_gen++;
      chk("hold_done", done_out, 1);
      chk("hold_gen", gen_count_out, exp_gen);
      repeat (20) @(negedge clk_130mhz);
      chk("hold_dropped_busy", busy_out, 0);
      chk("hold_dropped_wr", wr_cnt - w0, NWORDS);
      chk("hold_swaps", swap_cnt - s0, 1);
      take_swap();
      chk("hold_r0", rd_mem[widx(0, 0)], 16'h0003);

      clear_board();
      set_cell(2, 0);
      set_cell(2, 1);
      set_cell(2, 2);
      s0 = swap_cnt;
      pulse_start();
      repeat (500) @(negedge clk_130mhz);
      n = 0;
      while (!logic_wr_en && n < 20) begin
         @(negedge clk_130mhz);
         n++;
      end
      chk("mid_wr_seen", logic_wr_en, 1);
      rst_n_in = 1'b0;
      #1;
      chk("mid_rst_wr_en", logic_wr_en, 0);
      chk("mid_rst_busy", busy_out, 0);
      chk("mid_rst_gen", gen_count_out, 0);
      repeat (2) @(negedge clk_130mhz);
      rst_n_in = 1'b1;
      exp_gen = 0;
      repeat (CORE + 10) @(negedge clk_130mhz);
      chk("mid_no_swap", swap_cnt - s0, 0);
      chk("mid_idle", busy_out, 0);
      run_gen("fresh");
      chk("fresh_r0", rd_mem[widx(0, 0)], 0);
      chk("fresh_r1", rd_mem[widx(1, 0)], 16'h000E);
      chk("fresh_r2", rd_mem[widx(2, 0)], 0);
      chk("fresh_pop", board_pop(), 3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
